// File: rtl/and3_test_pkg.sv
// Purpose : shared types, constants and golden model for the AND3 vector sequencer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: state_t (FSM encoding), NUM_VEC / VEC_W (vector space), expected_and3().
package and3_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;

  // Golden response of an ideal 3-input AND for vector {a,b,c}.
  function automatic logic expected_and3(input logic [VEC_W-1:0] vec);
    return vec[2] & vec[1] & vec[0];
  endfunction

endpackage

// File: rtl/and3_hold_timer.sv
// Purpose : per-vector hold counter; flags the sample cycle and the vector-advance cycle.
// Latency : strobes are combinational from the counter register; counter restarts the cycle after i_clear.
// Backpressure: none; counts every cycle while i_run is high.
//
// Ports:
//   clk, rst       clock / async active-high reset
//   i_clear        restart the count at 0 (sweep start)
//   i_run          count enable (FSM in RUN)
//   o_sample_now   high on the cycle whose closing edge samples dut_out
//   o_advance      high on the last cycle of the current vector
module and3_hold_timer #(
  parameter int HOLD_CYCLES   = 5,
  parameter int SETTLE_CYCLES = 4,
  localparam int CNT_W        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_sample_now,
  output logic o_advance
);

  logic [CNT_W-1:0] r_hold_cnt;

  assign o_sample_now = i_run && (r_hold_cnt == CNT_W'(SETTLE_CYCLES));
  assign o_advance    = i_run && (r_hold_cnt == CNT_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (i_clear) begin
      r_hold_cnt <= '0;
    end else if (i_run) begin
      // Wrapping at HOLD_CYCLES-1 gives back-to-back vectors with no gap cycles.
      if (o_advance) r_hold_cnt <= '0;
      else           r_hold_cnt <= r_hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/and3_vector_sequencer.sv
// Purpose : drives all 8 a/b/c combinations into an AND3 cell and checks its output against a&b&c.
// Latency : done rises 8*HOLD_CYCLES edges after the start edge; each vector sampled SETTLE_CYCLES after it is applied.
// Backpressure: none; start is ignored while a sweep is running.
//
// Ports:
//   clk, rst                 clock / async active-high reset
//   start                    sweep request, honoured in IDLE or DONE
//   dut_out                  output of the cell under test
//   a, b, c                  cell inputs, straight from the vector register
//   busy, done, pass         sweep status; pass = done && no errors
//   err_count                saturating mismatch count
//   fail_valid, fail_vec     first mismatching vector of this sweep
module and3_vector_sequencer
  import and3_test_pkg::*;
#(
  parameter int HOLD_CYCLES   = 5,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_out,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  state_t           r_state;
  state_t           w_next_state;
  logic [VEC_W-1:0] r_vec;
  logic [ERR_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [VEC_W-1:0] r_fail_vec;

  logic             w_start_go;
  logic             w_run;
  logic             w_sample_now;
  logic             w_advance;
  logic             w_last_vec;
  logic             w_mismatch;
  logic             w_busy;
  logic             w_done;

  assign w_run      = (r_state == RUN);
  assign w_start_go = start && (r_state != RUN);
  assign w_last_vec = (r_vec == VEC_W'(NUM_VEC - 1));
  // Case inequality so an X or Z from the cell is reported as a failure.
  assign w_mismatch = (dut_out !== expected_and3(r_vec));

  and3_hold_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_hold_timer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_go),
    .i_run       (w_run),
    .o_sample_now(w_sample_now),
    .o_advance   (w_advance)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_advance && w_last_vec) w_next_state = DONE;
      DONE:    if (start) w_next_state = RUN;
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs decode straight from the state register, so reset clears them immediately.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      RUN:     w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  // Vector stepping and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec        <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_start_go) begin
      r_vec        <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_run) begin
      // Sample and advance can share an edge when SETTLE_CYCLES == HOLD_CYCLES-1;
      // the compare then uses the vector that is just ending, which is intended.
      if (w_sample_now && w_mismatch) begin
        if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + ERR_W'(1);
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_fail_vec   <= r_vec;
        end
      end
      // The last vector stays on a/b/c after the sweep ends.
      if (w_advance && !w_last_vec) r_vec <= r_vec + VEC_W'(1);
    end
  end

  assign a          = r_vec[2];
  assign b          = r_vec[1];
  assign c          = r_vec[0];
  assign busy       = w_busy;
  assign done       = w_done;
  assign pass       = w_done && (r_err_count == '0);
  assign err_count  = r_err_count;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: doc/and3_vector_sequencer.md
Name: and3_vector_sequencer

Overview:
Stimulus-and-check stage that sits directly upstream of the 3-input CMOS AND cell. It drives the cell's a/b/c inputs and consumes its output.
On start it walks all 8 input combinations 000..111, holding each for a fixed number of clock cycles. It samples the cell output after a settle window and compares it against a golden a&b&c. It reports error count, first failing vector and pass/done status.
Replaces hand-written #5-delay stimulus blocks with a reusable clocked sequencer.

Parameters:
HOLD_CYCLES, 5, clock cycles each vector is held on a/b/c; legal range >= 2.
SETTLE_CYCLES, 4, cycles after a vector is applied before dut_out is sampled; legal range 1..HOLD_CYCLES-1.
ERR_W, 4, width of err_count.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  level-sampled start request, honoured only in IDLE or DONE.
dut_out  input  1  output of the AND3 cell under test.
a  output  1  DUT input a; equals vec[2].
b  output  1  DUT input b; equals vec[1].
c  output  1  DUT input c; equals vec[0].
busy  output  1  high while vectors are being applied.
done  output  1  high from end of sweep until next start or reset.
pass  output  1  done && err_count==0.
err_count  output  ERR_W  number of mismatching vectors; saturates at all-ones.
fail_valid  output  1  at least one mismatch seen this sweep.
fail_vec  output  3  first mismatching vector {a,b,c}; valid only when fail_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. All state is in registers.
- Reset values: all outputs 0; state IDLE; vec=0; hold_cnt=0.
- Reset asserted mid-sweep: outputs drop to 0 immediately (asynchronously); no partial results are retained.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1. At that edge: vec<=0, hold_cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, busy<=1.
- RUN, vector hold:
  - hold_cnt increments every cycle.
  - On the edge where hold_cnt==HOLD_CYCLES-1: hold_cnt<=0.
  - If vec!=7, vec<=vec+1. If vec==7: state<=DONE, busy<=0, done<=1.
  - Each vector is therefore presented for exactly HOLD_CYCLES cycles; there are no gap cycles between vectors.
- RUN, sampling:
  - On the edge where hold_cnt==SETTLE_CYCLES, dut_out is compared against the expected value vec[2]&vec[1]&vec[0].
  - The compare uses 4-state inequality: X or Z on dut_out counts as a mismatch.
  - On mismatch: err_count increments, saturating at all-ones. If fail_valid==0, then fail_vec<=vec and fail_valid<=1.
  - Exactly one sample is taken per vector.
- Latency: done rises on the edge 8*HOLD_CYCLES cycles after the start edge. With defaults, this is 40 cycles after start is sampled.
- start during RUN is ignored; a sweep is never restarted.
- DONE:
  - Outputs hold their values; a/b/c stay at 111.
  - start=1 re-enters RUN with the same clearing as IDLE->RUN, and done<=0 at that edge.
- pass is combinational from the done and err_count registers.
- a/b/c are driven directly from the vec register, so they are glitch-free.

Decomposition:
- Package and3_test_pkg:
  - state enum {IDLE, RUN, DONE};
  - NUM_VEC=8;
  - VEC_W=3;
  - function expected_and3(vec) returning the golden bit.
- Sub-module and3_hold_timer: HOLD_CYCLES counter exposing the sample_now and advance strobes. The FSM, compare and error logic stay in the top.

Test Plan:
1. HOLD=5, SETTLE=4, DUT = ideal AND, start pulse.
   - a/b/c step 000,001,...,111 every 5 cycles.
   - done rises 40 cycles after start; err_count=0, pass=1, fail_valid=0.
2. DUT stuck-at-0.
   - err_count=1, fail_vec=3'b111, fail_valid=1, pass=0.
3. DUT stuck-at-1.
   - err_count=7, fail_vec=3'b000, pass=0.
4. DUT drives X only while vector 010 is applied.
   - err_count=1, fail_vec=3'b010.
5. rst asserted mid-sweep while vec=3.
   - All outputs 0 immediately, without waiting for a clock edge; state IDLE.
   - A new start runs all 8 vectors, done after 40 cycles.
6. start held high throughout RUN: the sweep is unaffected.
   - After done, with DUT stuck-at-1 in the first sweep and an ideal DUT in the second, a second start clears err_count from 7 to 0 and deasserts done for 40 cycles.
